// File: rtl/quad_pkg.sv
// Shared encodings and decode helpers for the quadrature encoder front-end.
//   quad_state_e : filtered {A,B} pin level pair
//   quad_step_e  : per-cycle decode result
//   quad_step()  : classify a prev->cur transition
package quad_pkg;

  typedef enum logic [1:0] {
    Q_00 = 2'b00,
    Q_01 = 2'b01,
    Q_10 = 2'b10,
    Q_11 = 2'b11
  } quad_state_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2,
    STEP_ERR  = 2'd3
  } quad_step_e;

  localparam int unsigned VEL_PERIOD_DEFAULT = 500000;

  // Forward rotation order: 00 -> 10 -> 11 -> 01 -> 00
  function automatic quad_state_e quad_fwd_next(input quad_state_e s);
    case (s)
      Q_00:    return Q_10;
      Q_10:    return Q_11;
      Q_11:    return Q_01;
      default: return Q_00;
    endcase
  endfunction

  // Single-bit change decides direction; a two-bit change is unresolvable
  function automatic quad_step_e quad_step(input quad_state_e prev, input quad_state_e cur);
    logic [1:0] diff;
    diff = 2'(prev) ^ 2'(cur);
    if (diff == 2'b00)                   return STEP_NONE;
    else if (diff == 2'b11)              return STEP_ERR;
    else if (quad_fwd_next(prev) == cur) return STEP_INC;
    else                                 return STEP_DEC;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Two-flop synchroniser plus stable-run glitch filter for one encoder channel.
//   clk, reset : clock, async active-low reset
//   pin        : raw asynchronous input
//   level      : filtered level, toggles after FILTER_CYCLES consecutive disagreeing samples
//   stable_c   : level and synced input have agreed for FILTER_CYCLES cycles
module quad_glitch_filter #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic stable_c
);

  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [1:0]    warm;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] stab_cnt;

  // warm keeps the reset-value sync flops from counting as a stable pin level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      warm     <= 2'b00;
      level    <= 1'b0;
      run_cnt  <= '0;
      stab_cnt <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
      if (sync2 != level) begin
        stab_cnt <= '0;
        if (run_cnt == CW'(FILTER_CYCLES - 1)) begin
          level   <= sync2;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + CW'(1);
        end
      end else begin
        run_cnt <= '0;
        if (warm[1] && (stab_cnt != CW'(FILTER_CYCLES))) begin
          stab_cnt <= stab_cnt + CW'(1);
        end
      end
    end
  end

  assign stable_c = (stab_cnt == CW'(FILTER_CYCLES));

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front-end: filter A/B, 4x decode into a wrapping position count,
// direction and sticky illegal-transition flag, windowed velocity, and snapshot handshake.
//   clk, reset        : clock, async active-low reset
//   enc_a, enc_b      : raw encoder pins
//   clear, err_clr    : zero position count / clear sticky error (pulses)
//   snap_req/snap_ack : snapshot request pulse / ack pulse with snap_count, snap_vel
//   count, vel        : live position, last completed window step count (signed, saturated)
//   vel_valid, dir    : vel update pulse, last step direction (1 = forward)
//   err               : sticky illegal-transition flag
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned COUNT_WIDTH   = 16,
  parameter int unsigned VEL_WIDTH     = 16,
  parameter int unsigned VEL_PERIOD    = VEL_PERIOD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enc_a,
  input  logic                   enc_b,
  input  logic                   clear,
  input  logic                   err_clr,
  input  logic                   snap_req,
  output logic                   snap_ack,
  output logic [COUNT_WIDTH-1:0] snap_count,
  output logic [VEL_WIDTH-1:0]   snap_vel,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [VEL_WIDTH-1:0]   vel,
  output logic                   vel_valid,
  output logic                   dir,
  output logic                   err
);

  localparam int unsigned AW = VEL_WIDTH + 1;
  localparam int unsigned PW = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;
  localparam logic signed [AW-1:0] ACC_MAX   = {1'b0, {VEL_WIDTH{1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN   = {1'b1, {VEL_WIDTH{1'b0}}};
  localparam logic signed [AW-1:0] VEL_MAX_X = {2'b00, {(VEL_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] VEL_MIN_X = {2'b11, {(VEL_WIDTH-1){1'b0}}};

  logic               a_lvl, b_lvl;
  logic               a_stable_c, b_stable_c;
  logic               primed;
  quad_state_e        prev_state;
  quad_state_e        cur_state_c;
  quad_step_e         step_c;
  logic [PW-1:0]      period_cnt;
  logic               terminal_c;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next_c;
  logic [VEL_WIDTH-1:0] vel_sat_c;

  quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .clk      (clk),
    .reset    (reset),
    .pin      (enc_a),
    .level    (a_lvl),
    .stable_c (a_stable_c)
  );

  quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .clk      (clk),
    .reset    (reset),
    .pin      (enc_b),
    .level    (b_lvl),
    .stable_c (b_stable_c)
  );

  // Decode is masked until priming so power-up pin levels never count
  always_comb begin
    cur_state_c = quad_state_e'({a_lvl, b_lvl});
    step_c      = STEP_NONE;
    if (primed) step_c = quad_step(prev_state, cur_state_c);
  end

  // Priming and previous-state tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      primed     <= 1'b0;
      prev_state <= Q_00;
    end else if (primed) begin
      prev_state <= cur_state_c;
    end else if (a_stable_c && b_stable_c) begin
      primed     <= 1'b1;
      prev_state <= cur_state_c;
    end
  end

  // Position, direction and sticky error; clear beats a coincident step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      dir   <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (clear)                   count <= '0;
      else if (step_c == STEP_INC) count <= count + COUNT_WIDTH'(1);
      else if (step_c == STEP_DEC) count <= count - COUNT_WIDTH'(1);

      if (step_c == STEP_INC)      dir <= 1'b1;
      else if (step_c == STEP_DEC) dir <= 1'b0;

      if (step_c == STEP_ERR) err <= 1'b1;
      else if (err_clr)       err <= 1'b0;
    end
  end

  // Saturating accumulate including this cycle's step, then clamp to VEL_WIDTH
  always_comb begin
    acc_next_c = acc;
    if ((step_c == STEP_INC) && (acc != ACC_MAX))      acc_next_c = acc + AW'(1);
    else if ((step_c == STEP_DEC) && (acc != ACC_MIN)) acc_next_c = acc - AW'(1);
    vel_sat_c = acc_next_c[VEL_WIDTH-1:0];
    if (acc_next_c > VEL_MAX_X)      vel_sat_c = VEL_MAX_X[VEL_WIDTH-1:0];
    else if (acc_next_c < VEL_MIN_X) vel_sat_c = VEL_MIN_X[VEL_WIDTH-1:0];
  end

  assign terminal_c = (period_cnt == PW'(VEL_PERIOD - 1));

  // Velocity window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
      acc        <= '0;
      vel        <= '0;
      vel_valid  <= 1'b0;
    end else begin
      vel_valid <= terminal_c;
      if (terminal_c) begin
        period_cnt <= '0;
        acc        <= '0;
        vel        <= vel_sat_c;
      end else begin
        period_cnt <= period_cnt + PW'(1);
        acc        <= acc_next_c;
      end
    end
  end

  // Snapshot captures register values seen in the request cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_ack   <= 1'b0;
      snap_count <= '0;
      snap_vel   <= '0;
    end else begin
      snap_ack <= snap_req;
      if (snap_req) begin
        snap_count <= count;
        snap_vel   <= vel;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder (FILTER_CYCLES=4, VEL_PERIOD=100, 16-bit widths).
module tb_quad_decoder;

  localparam int unsigned FC = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned VW = 16;
  localparam int unsigned VP = 100;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [VW-1:0] vel;
  } snap_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enc_a, enc_b, clear, err_clr, snap_req;
  logic          snap_ack, vel_valid, dir, err;
  logic [CW-1:0] snap_count, count;
  logic [VW-1:0] snap_vel, vel;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_count;
  logic          exp_dir;
  int            idx;
  logic [1:0]    seq [4];
  snap_t         snap_q [$];
  logic [VW-1:0] vel_q [$];

  always #5 clk = ~clk;

  quad_decoder #(
    .FILTER_CYCLES (FC),
    .COUNT_WIDTH   (CW),
    .VEL_WIDTH     (VW),
    .VEL_PERIOD    (VP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .clear      (clear),
    .err_clr    (err_clr),
    .snap_req   (snap_req),
    .snap_ack   (snap_ack),
    .snap_count (snap_count),
    .snap_vel   (snap_vel),
    .count      (count),
    .vel        (vel),
    .vel_valid  (vel_valid),
    .dir        (dir),
    .err        (err)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pins(input int i);
    logic [1:0] p;
    idx   = i;
    p     = seq[i];
    enc_a = p[1];
    enc_b = p[0];
  endtask

  task automatic step(input bit fwd);
    if (fwd) begin
      set_pins((idx + 1) % 4);
      exp_count = exp_count + 16'd1;
    end else begin
      set_pins((idx + 3) % 4);
      exp_count = exp_count - 16'd1;
    end
    exp_dir = fwd;
    tick(10);
  endtask

  task automatic wait_vel_valid(input int limit, output bit seen);
    int n = 0;
    while (vel_valid !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    seen = (vel_valid === 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b0; clear = 1'b0; err_clr = 1'b0; snap_req = 1'b0;
    set_pins(2);
    exp_count = '0; exp_dir = 1'b0;
    tick(3);
    checks++;
    if (count !== 16'h0000) begin
      errors++; $display("FAIL reset_count got %h want 0000", count);
    end
    checks++;
    if ({dir, err, vel_valid, snap_ack} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {dir, err, vel_valid, snap_ack});
    end
    checks++;
    if ({vel, snap_count, snap_vel} !== 48'h0) begin
      errors++; $display("FAIL reset_regs got %h want 0", {vel, snap_count, snap_vel});
    end
  endtask

  task automatic test_prime;
    bit seen;
    logic [VW-1:0] ev;
    reset = 1'b1;
    vel_q.push_back(16'h0000);
    tick(50);
    checks++;
    if ({count, err, dir} !== {16'h0000, 2'b00}) begin
      errors++; $display("FAIL prime_idle got %h/%b/%b want 0000/0/0", count, err, dir);
    end
    wait_vel_valid(200, seen);
    ev = vel_q.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL prime_vel_timeout got no vel_valid want pulse");
    end else begin
      checks++;
      if (vel !== ev) begin
        errors++; $display("FAIL prime_vel got %h want %h", vel, ev);
      end
    end
  endtask

  task automatic test_steps;
    for (int i = 0; i < 8; i++) step(1'b1);
    checks++;
    if (count !== exp_count || dir !== 1'b1) begin
      errors++; $display("FAIL fwd8 got %h/%b want %h/1", count, dir, exp_count);
    end
    for (int i = 0; i < 3; i++) step(1'b0);
    checks++;
    if (count !== 16'd5 || count !== exp_count || dir !== 1'b0) begin
      errors++; $display("FAIL rev3 got %h/%b want 0005/0", count, dir);
    end
  endtask

  task automatic test_glitch;
    logic [CW-1:0] c;
    logic [1:0]    np, cp;
    int            nidx;
    logic [CW-1:0] mid;
    c = exp_count;
    enc_a = ~enc_a; tick(3); enc_a = ~enc_a;
    tick(15);
    checks++;
    if (count !== c) begin
      errors++; $display("FAIL glitch3 got %h want %h", count, c);
    end
    cp   = seq[idx];
    np   = {~cp[1], cp[0]};
    nidx = 0;
    for (int i = 0; i < 4; i++) if (seq[i] == np) nidx = i;
    mid = (((nidx - idx + 4) % 4) == 1) ? c + 16'd1 : c - 16'd1;
    enc_a = ~enc_a; tick(5); enc_a = ~enc_a;
    tick(4);
    checks++;
    if (count !== mid) begin
      errors++; $display("FAIL pulse5_mid got %h want %h", count, mid);
    end
    tick(10);
    exp_dir = (mid != c + 16'd1);
    checks++;
    if (count !== c || dir !== exp_dir) begin
      errors++; $display("FAIL pulse5_end got %h/%b want %h/%b", count, dir, c, exp_dir);
    end
  endtask

  task automatic test_wrap_clear;
    clear = 1'b1; tick(1); clear = 1'b0;
    exp_count = '0;
    tick(1);
    checks++;
    if (count !== 16'h0000) begin
      errors++; $display("FAIL clear got %h want 0000", count);
    end
    step(1'b0);
    checks++;
    if (count !== 16'hFFFF) begin
      errors++; $display("FAIL under got %h want FFFF", count);
    end
    set_pins((idx + 1) % 4);
    tick(6);
    checks++;
    if (count !== 16'hFFFF) begin
      errors++; $display("FAIL latency_early got %h want FFFF", count);
    end
    tick(1);
    checks++;
    if (count !== 16'h0000) begin
      errors++; $display("FAIL wrap got %h want 0000", count);
    end
    tick(3);
    set_pins((idx + 3) % 4);
    tick(6);
    clear = 1'b1; tick(1); clear = 1'b0;
    exp_count = '0; exp_dir = 1'b0;
    tick(3);
    checks++;
    if (count !== 16'h0000 || dir !== 1'b0) begin
      errors++; $display("FAIL clear_step got %h/%b want 0000/0", count, dir);
    end
  endtask

  task automatic test_illegal;
    logic [CW-1:0] c;
    while (idx != 0) step(1'b1);
    c = exp_count;
    set_pins(2);
    tick(10);
    checks++;
    if (err !== 1'b1 || count !== c) begin
      errors++; $display("FAIL illegal got %b/%h want 1/%h", err, count, c);
    end
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clr got %b want 0", err);
    end
    set_pins(0);
    tick(6);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    tick(2);
    checks++;
    if (err !== 1'b1 || count !== c) begin
      errors++; $display("FAIL err_set_wins got %b/%h want 1/%h", err, count, c);
    end
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clr2 got %b want 0", err);
    end
  endtask

  task automatic test_velocity_snapshot;
    bit seen;
    logic [VW-1:0] ev;
    snap_t es;
    wait_vel_valid(200, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL vel_sync_timeout got no vel_valid want pulse");
    end
    vel_q.push_back(16'd5);
    for (int i = 0; i < 5; i++) step(1'b1);
    wait_vel_valid(150, seen);
    ev = vel_q.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL vel5_timeout got no vel_valid want pulse");
    end else if (vel !== ev) begin
      errors++; $display("FAIL vel5 got %h want %h", vel, ev);
    end
    tick(1);
    checks++;
    if (vel_valid !== 1'b0) begin
      errors++; $display("FAIL vel_valid_width got %b want 0", vel_valid);
    end
    snap_req = 1'b1;
    snap_q.push_back('{cnt: exp_count, vel: 16'd5});
    tick(1);
    snap_req = 1'b0;
    es = snap_q.pop_front();
    checks++;
    if (snap_ack !== 1'b1 || snap_count !== es.cnt || snap_vel !== es.vel) begin
      errors++; $display("FAIL snap got %b/%h/%h want 1/%h/%h", snap_ack, snap_count, snap_vel, es.cnt, es.vel);
    end
    tick(1);
    checks++;
    if (snap_ack !== 1'b0) begin
      errors++; $display("FAIL snap_ack_width got %b want 0", snap_ack);
    end
  endtask

  task automatic test_back_to_back;
    bit seen;
    logic [VW-1:0] ev;
    snap_t es;
    logic [CW-1:0] old_c;
    vel_q.push_back(16'h0000);
    wait_vel_valid(200, seen);
    ev = vel_q.pop_front();
    checks++;
    if (!seen || vel !== ev) begin
      errors++; $display("FAIL vel_idle got %b/%h want 1/%h", seen, vel, ev);
    end
    old_c = exp_count;
    set_pins((idx + 1) % 4);
    exp_count = exp_count + 16'd1; exp_dir = 1'b1;
    tick(6);
    snap_req = 1'b1;
    snap_q.push_back('{cnt: old_c, vel: 16'h0000});
    tick(1);
    es = snap_q.pop_front();
    checks++;
    if (snap_ack !== 1'b1 || snap_count !== es.cnt || snap_vel !== es.vel) begin
      errors++; $display("FAIL b2b_first got %b/%h/%h want 1/%h/%h", snap_ack, snap_count, snap_vel, es.cnt, es.vel);
    end
    snap_q.push_back('{cnt: exp_count, vel: 16'h0000});
    tick(1);
    snap_req = 1'b0;
    es = snap_q.pop_front();
    checks++;
    if (snap_ack !== 1'b1 || snap_count !== es.cnt || snap_vel !== es.vel) begin
      errors++; $display("FAIL b2b_second got %b/%h/%h want 1/%h/%h", snap_ack, snap_count, snap_vel, es.cnt, es.vel);
    end
    tick(1);
    checks++;
    if (snap_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_end got %b want 0", snap_ack);
    end
    tick(5);
  endtask

  task automatic test_reset_mid;
    bit saw_ack = 1'b0;
    bit saw_err = 1'b0;
    bit saw_cnt = 1'b0;
    snap_req = 1'b1;
    #2 reset = 1'b0;
    set_pins(2);
    tick(2);
    snap_req = 1'b0;
    exp_count = '0; exp_dir = 1'b0;
    checks++;
    if ({count, dir, err, snap_ack, snap_count} !== 35'h0) begin
      errors++; $display("FAIL reset_mid got %h/%b/%b/%b/%h want 0", count, dir, err, snap_ack, snap_count);
    end
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (snap_ack === 1'b1) saw_ack = 1'b1;
      if (err === 1'b1) saw_err = 1'b1;
      if (count !== 16'h0000) saw_cnt = 1'b1;
    end
    checks++;
    if ({saw_ack, saw_err, saw_cnt} !== 3'b000) begin
      errors++; $display("FAIL reprime got ack/err/cnt %b%b%b want 000", saw_ack, saw_err, saw_cnt);
    end
    step(1'b1);
    checks++;
    if (count !== 16'h0001 || dir !== 1'b1) begin
      errors++; $display("FAIL after_reset_step got %h/%b want 0001/1", count, dir);
    end
  endtask

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    test_reset;
    test_prime;
    test_steps;
    test_glitch;
    test_wrap_clear;
    test_illegal;
    test_velocity_snapshot;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
